// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants and types for EX forwarding, ID hazard detection
// and the long-latency (MUL/DIV) register scoreboard.
package hazard_scoreboard_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;
   localparam int MAX_LAT_DEF    = 34;
   // Raw latency field width; wide enough for any requested latency before clamping.
   localparam int LAT_OP_CYC_W   = 8;

   // Forward-select encoding: 0 = register file, k = forwarding stage k-1.
   typedef enum logic [1:0] {
      FW_NONE = 2'd0,
      FW_MEM  = 2'd1,
      FW_WB   = 2'd2
   } fw_sel_e;

   function automatic int unsigned fw_stage(input int unsigned k);
      return k + 1;
   endfunction

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic [LAT_OP_CYC_W-1:0]   cycles;
   } lat_op_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Signal bundle between the pipeline control (master) and the hazard unit (slave).
interface hazard_scoreboard_if #(
   parameter int NUM_FWD   = 2,
   parameter int LAT_W     = 6,
   parameter int FWD_SEL_W = 2,
   parameter int PERF_W    = 32
);
   import hazard_scoreboard_pkg::*;

   logic [REG_ADDR_WIDTH-1:0]              rs1_addr_EX_i;
   logic [REG_ADDR_WIDTH-1:0]              rs2_addr_EX_i;
   logic [NUM_FWD-1:0]                     fwd_regwrite_i;
   logic [NUM_FWD-1:0][REG_ADDR_WIDTH-1:0] fwd_rd_i;
   logic [NUM_FWD-1:0]                     fwd_is_load_i;
   logic                                   ex_regwrite_i;
   logic                                   ex_is_load_i;
   logic [REG_ADDR_WIDTH-1:0]              ex_rd_i;
   // Handshake: ID advances at an edge only when id_valid_i && !stall_o;
   // stall_o is the inverted ready and never depends on kill_i.
   logic                                   id_valid_i;
   logic [REG_ADDR_WIDTH-1:0]              id_rs1_i;
   logic [REG_ADDR_WIDTH-1:0]              id_rs2_i;
   logic [REG_ADDR_WIDTH-1:0]              id_rd_i;
   logic                                   id_use_rs1_i;
   logic                                   id_use_rs2_i;
   logic                                   id_regwrite_i;
   logic                                   id_lat_op_i;
   logic [LAT_W-1:0]                       id_lat_cycles_i;
   logic                                   kill_i;
   logic [FWD_SEL_W-1:0]                   fwd_a_sel_o;
   logic [FWD_SEL_W-1:0]                   fwd_b_sel_o;
   logic                                   fwd_a_mem_o;
   logic                                   fwd_b_mem_o;
   logic                                   stall_o;
   logic                                   lat_busy_o;
   logic                                   lat_done_o;
   logic [REG_ADDR_WIDTH-1:0]              lat_done_rd_o;
   logic [PERF_W-1:0]                      stall_cnt_o;

   modport master (
      output rs1_addr_EX_i, rs2_addr_EX_i, fwd_regwrite_i, fwd_rd_i, fwd_is_load_i,
             ex_regwrite_i, ex_is_load_i, ex_rd_i, id_valid_i, id_rs1_i, id_rs2_i,
             id_rd_i, id_use_rs1_i, id_use_rs2_i, id_regwrite_i, id_lat_op_i,
             id_lat_cycles_i, kill_i,
      input  fwd_a_sel_o, fwd_b_sel_o, fwd_a_mem_o, fwd_b_mem_o, stall_o,
             lat_busy_o, lat_done_o, lat_done_rd_o, stall_cnt_o
   );

   modport slave (
      input  rs1_addr_EX_i, rs2_addr_EX_i, fwd_regwrite_i, fwd_rd_i, fwd_is_load_i,
             ex_regwrite_i, ex_is_load_i, ex_rd_i, id_valid_i, id_rs1_i, id_rs2_i,
             id_rd_i, id_use_rs1_i, id_use_rs2_i, id_regwrite_i, id_lat_op_i,
             id_lat_cycles_i, kill_i,
      output fwd_a_sel_o, fwd_b_sel_o, fwd_a_mem_o, fwd_b_mem_o, stall_o,
             lat_busy_o, lat_done_o, lat_done_rd_o, stall_cnt_o
   );

endinterface

// File: rtl/hazard_scoreboard_lat_scoreboard.sv
// Countdown, busy-register vector and completion tracking for the single
// non-pipelined long-latency unit.
module lat_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int MAX_LAT = MAX_LAT_DEF,
   parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      issue,
   input  lat_op_t                   op,
   input  logic                      kill,
   output logic [NUM_REGS-1:0]       busy_vec,
   output logic                      lat_busy,
   output logic                      lat_done,
   output logic [REG_ADDR_WIDTH-1:0] lat_done_rd
);

   logic [LAT_W-1:0]          cnt;
   logic [LAT_W-1:0]          cnt_init;
   logic [REG_ADDR_WIDTH-1:0] lat_rd;
   logic [REG_ADDR_WIDTH-1:0] done_rd_q;
   logic [NUM_REGS-1:0]       busy;

   // A zero latency still occupies the unit for one cycle.
   always_comb begin
      cnt_init = op.cycles[LAT_W-1:0];
      if (op.cycles == '0)
         cnt_init = LAT_W'(1);
      else if (op.cycles > LAT_OP_CYC_W'(MAX_LAT))
         cnt_init = LAT_W'(MAX_LAT);
   end

   assign lat_busy    = (cnt != '0);
   assign lat_done    = (cnt == LAT_W'(1)) && !kill;
   assign lat_done_rd = lat_done ? lat_rd : done_rd_q;
   assign busy_vec    = busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         lat_rd    <= '0;
         done_rd_q <= '0;
         busy      <= '0;
      end else if (kill) begin
         cnt  <= '0;
         busy <= '0;
      end else begin
         if (cnt != '0)
            cnt <= cnt - LAT_W'(1);
         if (lat_done) begin
            busy[lat_rd] <= 1'b0;
            done_rd_q    <= lat_rd;
         end
         // Issue is blocked while the unit is busy, so it never races a clear.
         if (issue) begin
            cnt    <= cnt_init;
            lat_rd <= op.rd;
            if (op.valid && op.rd != '0)
               busy[op.rd] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// EX forwarding priority mux, ID load-use / scoreboard / structural stall
// generation and a saturating stall-cycle counter.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_FWD   = 2,
   parameter int MAX_LAT   = MAX_LAT_DEF,
   parameter int LAT_W     = $clog2(MAX_LAT + 1),
   parameter int FWD_SEL_W = $clog2(NUM_FWD + 1),
   parameter int PERF_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   hazard_scoreboard_if.slave  bus
);

   logic [NUM_REGS-1:0] busy_vec;
   logic                load_use;
   logic                sb_stall;
   logic                struct_stall;
   logic                stall;
   logic                issue;
   logic [PERF_W-1:0]   stall_cnt;
   logic [FWD_SEL_W:0]  pick_a;
   logic [FWD_SEL_W:0]  pick_b;
   lat_op_t             op;

   // Returns {mem_flag, sel}; iterating oldest-first lets the youngest match win.
   function automatic logic [FWD_SEL_W:0] fwd_pick(
      input logic [REG_ADDR_WIDTH-1:0]              rs,
      input logic [NUM_FWD-1:0]                     we,
      input logic [NUM_FWD-1:0][REG_ADDR_WIDTH-1:0] rd,
      input logic [NUM_FWD-1:0]                     ld
   );
      logic [FWD_SEL_W:0] r;
      r = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (we[k] && rd[k] != '0 && rd[k] == rs)
            r = {ld[k], FWD_SEL_W'(fw_stage(k))};
      end
      return r;
   endfunction

   assign pick_a = fwd_pick(bus.rs1_addr_EX_i, bus.fwd_regwrite_i, bus.fwd_rd_i, bus.fwd_is_load_i);
   assign pick_b = fwd_pick(bus.rs2_addr_EX_i, bus.fwd_regwrite_i, bus.fwd_rd_i, bus.fwd_is_load_i);

   assign bus.fwd_a_sel_o = pick_a[FWD_SEL_W-1:0];
   assign bus.fwd_a_mem_o = pick_a[FWD_SEL_W];
   assign bus.fwd_b_sel_o = pick_b[FWD_SEL_W-1:0];
   assign bus.fwd_b_mem_o = pick_b[FWD_SEL_W];

   assign load_use = bus.id_valid_i && bus.ex_regwrite_i && bus.ex_is_load_i &&
                     bus.ex_rd_i != '0 &&
                     ((bus.id_use_rs1_i && bus.id_rs1_i == bus.ex_rd_i) ||
                      (bus.id_use_rs2_i && bus.id_rs2_i == bus.ex_rd_i));

   assign sb_stall = bus.id_valid_i &&
                     ((bus.id_use_rs1_i && busy_vec[bus.id_rs1_i]) ||
                      (bus.id_use_rs2_i && busy_vec[bus.id_rs2_i]) ||
                      (bus.id_regwrite_i && busy_vec[bus.id_rd_i]));

   assign struct_stall = bus.id_valid_i && bus.id_lat_op_i && bus.lat_busy_o;
   assign stall        = load_use || sb_stall || struct_stall;
   assign issue        = bus.id_valid_i && bus.id_lat_op_i && !stall && !bus.kill_i;

   assign op.valid  = bus.id_regwrite_i;
   assign op.rd     = bus.id_rd_i;
   assign op.cycles = LAT_OP_CYC_W'(bus.id_lat_cycles_i);

   lat_scoreboard #(
      .MAX_LAT (MAX_LAT),
      .LAT_W   (LAT_W)
   ) u_lat (
      .clk         (clk),
      .rst         (rst),
      .issue       (issue),
      .op          (op),
      .kill        (bus.kill_i),
      .busy_vec    (busy_vec),
      .lat_busy    (bus.lat_busy_o),
      .lat_done    (bus.lat_done_o),
      .lat_done_rd (bus.lat_done_rd_o)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (stall && stall_cnt != '1)
         stall_cnt <= stall_cnt + PERF_W'(1);
   end

   assign bus.stall_o     = stall;
   assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, load-use, long-op
// scoreboard, kill, async reset and counter saturation.
module tb_hazard_scoreboard;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fails;
   logic [36:0] exp_q[$];

   hazard_scoreboard_if #(.NUM_FWD(2), .LAT_W(6), .FWD_SEL_W(2), .PERF_W(4)) bus ();

   hazard_scoreboard #(
      .NUM_FWD   (2),
      .MAX_LAT   (34),
      .LAT_W     (6),
      .FWD_SEL_W (2),
      .PERF_W    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.rs1_addr_EX_i   = '0;
      bus.rs2_addr_EX_i   = '0;
      bus.fwd_regwrite_i  = '0;
      bus.fwd_rd_i        = '0;
      bus.fwd_is_load_i   = '0;
      bus.ex_regwrite_i   = 1'b0;
      bus.ex_is_load_i    = 1'b0;
      bus.ex_rd_i         = '0;
      bus.id_valid_i      = 1'b0;
      bus.id_rs1_i        = '0;
      bus.id_rs2_i        = '0;
      bus.id_rd_i         = '0;
      bus.id_use_rs1_i    = 1'b0;
      bus.id_use_rs2_i    = 1'b0;
      bus.id_regwrite_i   = 1'b0;
      bus.id_lat_op_i     = 1'b0;
      bus.id_lat_cycles_i = '0;
      bus.kill_i          = 1'b0;
   endtask

   task automatic drive_lat_op(input logic [4:0] rd, input logic [5:0] cycles);
      idle();
      bus.id_valid_i      = 1'b1;
      bus.id_lat_op_i     = 1'b1;
      bus.id_regwrite_i   = 1'b1;
      bus.id_rd_i         = rd;
      bus.id_lat_cycles_i = cycles;
   endtask

   task automatic drive_load_use();
      idle();
      bus.ex_regwrite_i = 1'b1;
      bus.ex_is_load_i  = 1'b1;
      bus.ex_rd_i       = 5'd7;
      bus.id_valid_i    = 1'b1;
      bus.id_rs2_i      = 5'd7;
      bus.id_use_rs2_i  = 1'b1;
   endtask

   // monitor: every done pulse must match the next expected {cycle, rd}
   task automatic monitor();
      logic [36:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus.lat_done_o) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL unexpected_done: got rd %0d at cycle %0d expected no pulse",
                        bus.lat_done_rd_o, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("done_cycle_rd", {cyc[31:0], bus.lat_done_rd_o}, {27'd0, e});
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      cyc      = 0;
      rst      = 1'b1;
      idle();
      fork
         monitor();
      join_none
      #2;
      chk("rst_busy", bus.lat_busy_o, 0);
      chk("rst_done", bus.lat_done_o, 0);
      chk("rst_done_rd", bus.lat_done_rd_o, 0);
      chk("rst_stall", bus.stall_o, 0);
      chk("rst_stall_cnt", bus.stall_cnt_o, 0);
      step();
      step();
      rst = 1'b0;

      // forwarding priority
      bus.fwd_regwrite_i = 2'b11;
      bus.fwd_rd_i[0]    = 5'd5;
      bus.fwd_rd_i[1]    = 5'd5;
      bus.fwd_is_load_i  = 2'b01;
      bus.rs1_addr_EX_i  = 5'd5;
      bus.rs2_addr_EX_i  = 5'd3;
      #1;
      chk("fwd_a_sel_young", bus.fwd_a_sel_o, 1);
      chk("fwd_a_mem_young", bus.fwd_a_mem_o, 1);
      chk("fwd_b_sel_nomatch", bus.fwd_b_sel_o, 0);
      bus.fwd_regwrite_i = 2'b10;
      bus.rs2_addr_EX_i  = 5'd5;
      #1;
      chk("fwd_b_sel_old", bus.fwd_b_sel_o, 2);
      chk("fwd_b_mem_old", bus.fwd_b_mem_o, 0);
      bus.fwd_regwrite_i = 2'b11;
      bus.fwd_rd_i       = '0;
      bus.rs1_addr_EX_i  = 5'd0;
      bus.rs2_addr_EX_i  = 5'd0;
      #1;
      chk("fwd_a_sel_x0", bus.fwd_a_sel_o, 0);
      chk("fwd_b_sel_x0", bus.fwd_b_sel_o, 0);
      chk("fwd_a_mem_x0", bus.fwd_a_mem_o, 0);

      // load-use
      step();
      drive_load_use();
      #1;
      chk("lu_stall", bus.stall_o, 1);
      bus.id_use_rs2_i = 1'b0;
      #1;
      chk("lu_no_use", bus.stall_o, 0);
      idle();

      // long op to x9, 4 cycles, with a dependent reader behind it
      step();
      drive_lat_op(5'd9, 6'd4);
      #1;
      chk("div_issue_nostall", bus.stall_o, 0);
      step();
      exp_q.push_back({cyc[31:0] + 32'd3, 5'd9});
      idle();
      bus.id_valid_i   = 1'b1;
      bus.id_rs1_i     = 5'd9;
      bus.id_use_rs1_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk("div_busy", bus.lat_busy_o, 1);
         chk("div_dep_stall", bus.stall_o, 1);
         step();
      end
      chk("div_free", bus.lat_busy_o, 0);
      chk("div_dep_go", bus.stall_o, 0);

      // cycles = 0 acts as 1; structural stall on a second long op
      idle();
      step();
      drive_lat_op(5'd10, 6'd0);
      step();
      exp_q.push_back({cyc[31:0], 5'd10});
      drive_lat_op(5'd11, 6'd50);
      #1;
      chk("struct_stall", bus.stall_o, 1);
      step();
      chk("struct_release", bus.stall_o, 0);
      chk("lat0_free", bus.lat_busy_o, 0);
      step();
      exp_q.push_back({cyc[31:0] + 32'd33, 5'd11});
      // WAW: ID writes x11 while the clamped op is outstanding
      idle();
      bus.id_valid_i    = 1'b1;
      bus.id_regwrite_i = 1'b1;
      bus.id_rd_i       = 5'd11;
      #1;
      chk("waw_stall", bus.stall_o, 1);
      for (int i = 0; i < 33; i++) step();
      chk("clamp_busy_last", bus.lat_busy_o, 1);
      chk("clamp_stall_last", bus.stall_o, 1);
      step();
      chk("clamp_free", bus.lat_busy_o, 0);
      chk("waw_release", bus.stall_o, 0);

      // kill at cnt = 2
      idle();
      drive_lat_op(5'd12, 6'd4);
      step();
      idle();
      bus.id_valid_i   = 1'b1;
      bus.id_rs2_i     = 5'd12;
      bus.id_use_rs2_i = 1'b1;
      step();
      step();
      bus.kill_i = 1'b1;
      #1;
      chk("kill_dep_stall", bus.stall_o, 1);
      step();
      bus.kill_i = 1'b0;
      #1;
      chk("kill_busy_clear", bus.lat_busy_o, 0);
      chk("kill_dep_go", bus.stall_o, 0);
      chk("done_rd_held", bus.lat_done_rd_o, 11);

      // kill coincident with issue
      drive_lat_op(5'd13, 6'd3);
      bus.kill_i = 1'b1;
      step();
      idle();
      #1;
      chk("kill_issue_none", bus.lat_busy_o, 0);
      step();
      chk("kill_issue_none2", bus.lat_busy_o, 0);

      // async reset mid-op
      drive_lat_op(5'd14, 6'd10);
      step();
      idle();
      step();
      step();
      chk("pre_rst_busy", bus.lat_busy_o, 1);
      rst = 1'b1;
      #1;
      chk("arst_busy", bus.lat_busy_o, 0);
      chk("arst_done", bus.lat_done_o, 0);
      chk("arst_done_rd", bus.lat_done_rd_o, 0);
      chk("arst_stall_cnt", bus.stall_cnt_o, 0);
      step();
      step();
      rst = 1'b0;

      // stall counter saturation (4-bit)
      #1;
      chk("perf_start", bus.stall_cnt_o, 0);
      drive_load_use();
      for (int i = 0; i < 13; i++) step();
      chk("perf_13", bus.stall_cnt_o, 13);
      step();
      step();
      chk("perf_sat", bus.stall_cnt_o, 15);
      step();
      chk("perf_hold", bus.stall_cnt_o, 15);
      idle();
      step();
      step();

      chk("exp_q_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle EX forwarding logic.
- Resolves EX-operand forwarding across NUM_FWD younger-to-older pipeline stages.
- Detects load-use hazards in ID.
- Adds a register scoreboard for one non-pipelined long-latency unit (MUL/DIV), producing an ID stall, a completion pulse, and a saturating stall-cycle performance counter.

Parameters:
- NUM_FWD, 2: number of forwarding source stages; index 0 = youngest (MEM), highest = oldest (WB).
- MAX_LAT, 34: maximum long-op latency in cycles.
- LAT_W, $clog2(MAX_LAT+1): latency counter width.
- FWD_SEL_W, $clog2(NUM_FWD+1): forward-select width.
- PERF_W, 32: stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rs1_addr_EX_i  in  REG_ADDR_WIDTH  EX operand A register.
- rs2_addr_EX_i  in  REG_ADDR_WIDTH  EX operand B register.
- fwd_regwrite_i  in  NUM_FWD  per-stage RegWrite.
- fwd_rd_i  in  NUM_FWD x REG_ADDR_WIDTH  per-stage destination register.
- fwd_is_load_i  in  NUM_FWD  stage result comes from memory (WBSel == WB_MEM).
- ex_regwrite_i  in  1  EX instruction writes a register.
- ex_is_load_i  in  1  EX instruction is a load.
- ex_rd_i  in  REG_ADDR_WIDTH  EX destination register.
- id_valid_i  in  1  ID holds a valid instruction.
- id_rs1_i  in  REG_ADDR_WIDTH  ID source 1.
- id_rs2_i  in  REG_ADDR_WIDTH  ID source 2.
- id_rd_i  in  REG_ADDR_WIDTH  ID destination.
- id_use_rs1_i  in  1  ID reads rs1.
- id_use_rs2_i  in  1  ID reads rs2.
- id_regwrite_i  in  1  ID writes rd.
- id_lat_op_i  in  1  ID instruction is a long-latency op.
- id_lat_cycles_i  in  LAT_W  latency of that op.
- kill_i  in  1  cancels the in-flight long op (exception/flush).
- fwd_a_sel_o  out  FWD_SEL_W  0 = none, k = stage k-1.
- fwd_b_sel_o  out  FWD_SEL_W  0 = none, k = stage k-1.
- fwd_a_mem_o  out  1  selected A source is load data.
- fwd_b_mem_o  out  1  selected B source is load data.
- stall_o  out  1  hold PC/IF/ID, bubble into EX.
- lat_busy_o  out  1  long-latency unit occupied.
- lat_done_o  out  1  long op completes this cycle.
- lat_done_rd_o  out  REG_ADDR_WIDTH  destination of the completing op.
- stall_cnt_o  out  PERF_W  stall cycles, saturating.

Behaviour:
- Forwarding (combinational): for each operand, the lowest stage index k with fwd_regwrite_i[k], fwd_rd_i[k] != 0 and rd == rs wins; sel = k+1, mem flag = fwd_is_load_i[k]. No match gives sel = 0, mem = 0. x0 is never forwarded.
- Load-use (combinational): id_valid_i && ex_regwrite_i && ex_is_load_i && ex_rd_i != 0 && ((id_use_rs1_i && id_rs1_i == ex_rd_i) || (id_use_rs2_i && id_rs2_i == ex_rd_i)).
- Scoreboard stall (combinational): id_valid_i && (busy[rs1] used || busy[rs2] used || (id_regwrite_i && busy[rd])). Covers RAW and WAW; x0 is never busy.
- Structural stall: id_valid_i && id_lat_op_i && lat_busy_o.
- stall_o = OR of load-use, scoreboard and structural stalls. It is asserted conservatively through the lat_done cycle and released the following cycle.
- Issue: id_valid_i && id_lat_op_i && !stall_o && !kill_i at edge T.
  - At T+1: cnt = clamp(id_lat_cycles_i, 1, MAX_LAT) (0 is treated as 1); lat_rd = id_rd_i; busy[id_rd_i] set if id_regwrite_i and rd != 0.
- Countdown: lat_busy_o = (cnt != 0). While cnt != 0, cnt decrements every cycle.
- Completion: lat_done_o = (cnt == 1) && !kill_i, with lat_done_rd_o = lat_rd. At the next edge, busy[lat_rd] clears and cnt becomes 0. Completion is therefore visible exactly N cycles after issue.
- lat_done_rd_o is held at its last value when lat_done_o = 0.
- kill_i: takes priority over issue and completion. At the next edge, cnt = 0 and all busy bits clear; lat_done_o is suppressed combinationally.
- Perf counter: stall_cnt_o increments at each edge where stall_o = 1; it saturates at all-ones and does not wrap.
- Reset (asynchronous): cnt = 0, busy = 0, lat_rd = 0, stall_cnt = 0. Consequently lat_busy_o = 0, lat_done_o = 0, lat_done_rd_o = 0, stall_o = 0 (unless a load-use hazard is present). Reset asserted mid-operation discards the in-flight op with no done pulse.

Decomposition:
- Shared core_pkg: REG_ADDR_WIDTH, the fw_sel_e extension (FW_STAGE encoding helper), MAX_LAT default, and a lat_op_t struct {valid, rd, cycles}.
- One natural sub-module: lat_scoreboard (counter, busy vector, lat_rd, done/kill logic).
- Forwarding priority mux and stall OR remain at top level.

Test Plan:
- Forwarding priority: stage0 and stage1 both write x5, EX rs1 = 5, stage0 is a load -> fwd_a_sel_o = 1, fwd_a_mem_o = 1. With rd = x0 on all stages -> sel = 0.
- Load-use: EX is a load to x7; ID uses rs2 = x7 -> stall_o = 1 for one cycle. If id_use_rs2_i = 0 -> stall_o = 0.
- Long op: issue DIV to x9 with cycles = 4 at T. Then lat_busy_o = 1 over T+1..T+4, lat_done_o = 1 at T+4 with rd = 9; a dependent ID on x9 stalls until T+5.
- Structural/WAW: a second lat op, or an ID write to x9 while busy -> stall_o held. Cycles = 0 behaves as 1; cycles = 50 clamps to 34.
- Kill during countdown at cnt = 2 -> no lat_done_o, busy clear next cycle, dependent instruction proceeds. Kill coincident with issue -> nothing issued.
- Async reset pulse mid-op -> all outputs 0 immediately. Preset stall_cnt near max and stall 3 cycles -> stall_cnt_o saturates at all-ones.
